// File: rtl/mux_ctrl_seq.sv
// Registered N:1 duty-word selector with manual and auto-scan modes, updated only on upd strobes.
// Optional MUX_CTRL_SEQ_SYNC_EN adds 2-flop synchronizers on sel and mode.
module mux_ctrl_seq #(
    parameter int WIDTH   = 7,
    parameter int NCH     = 4,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   d_in,
    input  logic [SELW-1:0]        sel,
    input  logic                   mode,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic                   upd,
    output logic [WIDTH-1:0]       y,
    output logic [SELW-1:0]        ch,
    output logic                   sw
);
    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t             state, state_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [SELW-1:0]    ch_nx, sel_c, sel_u;
    logic               mode_u;
    logic [WIDTH-1:0]   words [NCH];

`ifdef MUX_CTRL_SEQ_SYNC_EN
    logic [SELW-1:0] sel_s1, sel_s2;
    logic            mode_s1, mode_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1  <= '0;
            sel_s2  <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            sel_s1  <= sel;
            sel_s2  <= sel_s1;
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
        end
    end

    assign sel_u  = sel_s2;
    assign mode_u = mode_s2;
`else
    assign sel_u  = sel;
    assign mode_u = mode;
`endif

    // Out-of-range selects land on the last channel.
    assign sel_c = (sel_u > LAST) ? LAST : sel_u;

    for (genvar g = 0; g < NCH; g++) begin : g_word
        assign words[g] = d_in[g*WIDTH +: WIDTH];
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ch_nx    = ch;
        case (state)
            MANUAL: begin
                if (mode_u) begin
                    state_nx = AUTO;
                    cnt_nx   = '0;
                end else begin
                    ch_nx = sel_c;
                end
            end
            AUTO: begin
                if (!mode_u) begin
                    state_nx = MANUAL;
                    cnt_nx   = '0;
                    ch_nx    = sel_c;
                end else if (cnt >= dwell) begin
                    // dwell is live: lowering it below cnt forces an advance.
                    cnt_nx = '0;
                    ch_nx  = (ch == LAST) ? '0 : ch + 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MANUAL;
            cnt   <= '0;
            ch    <= '0;
            y     <= '0;
            sw    <= 1'b0;
        end else if (upd) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ch    <= ch_nx;
            y     <= words[ch_nx];
            sw    <= (ch_nx != ch);
        end else begin
            sw <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_ctrl_seq.sv
// Directed + randomized bench for mux_ctrl_seq (NCH=4 and NCH=3 instances side by side),
// checked against a period-level behavioural model.
module tb_mux_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] d_in = '0;
    logic [20:0] d_in3;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic [7:0]  dwell = '0;
    logic        upd = 1'b0;
    logic [6:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        sw4, sw3;

    int n_assert = 0;
    int n_fail   = 0;

    assign d_in3 = d_in[20:0];

    always #5 clk = ~clk;

    mux_ctrl_seq #(.WIDTH(7), .NCH(4), .SELW(2), .DWELL_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .sel(sel), .mode(mode),
        .dwell(dwell), .upd(upd), .y(y4), .ch(ch4), .sw(sw4));

    mux_ctrl_seq #(.WIDTH(7), .NCH(3), .SELW(2), .DWELL_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in3), .sel(sel), .mode(mode),
        .dwell(dwell), .upd(upd), .y(y3), .ch(ch3), .sw(sw3));

    // Reference model: index 0 models NCH=4, index 1 models NCH=3.
    int unsigned m_ch   [2];
    int unsigned m_y    [2];
    int unsigned m_sw   [2];
    int unsigned m_auto [2];
    int unsigned m_cnt  [2];
    int unsigned sel_h1, sel_h2, mode_h1, mode_h2;
    int unsigned eff_sel, eff_mode;

`ifdef MUX_CTRL_SEQ_SYNC_EN
    assign eff_sel  = sel_h2;
    assign eff_mode = mode_h2;
`else
    assign eff_sel  = 32'(sel);
    assign eff_mode = 32'(mode);
`endif

    // Returns {auto, cnt[7:0], ch[7:0]} after one period boundary.
    function automatic int unsigned period_step(int unsigned nch, int unsigned auto_m,
                                                int unsigned cnt, int unsigned chn,
                                                int unsigned s, int unsigned md,
                                                int unsigned dw);
        int unsigned cs = (s < nch) ? s : nch - 1;
        int unsigned a = auto_m, c = cnt, n = chn;
        if (auto_m == 0) begin
            if (md != 0) begin a = 1; c = 0; end
            else n = cs;
        end else if (md == 0) begin
            a = 0; c = 0; n = cs;
        end else if (cnt >= dw) begin
            c = 0; n = (chn + 1) % nch;
        end else begin
            c = cnt + 1;
        end
        return (a << 16) | (c << 8) | n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ch[k] <= 0; m_y[k] <= 0; m_sw[k] <= 0; m_auto[k] <= 0; m_cnt[k] <= 0;
            end
            sel_h1 <= 0; sel_h2 <= 0; mode_h1 <= 0; mode_h2 <= 0;
        end else begin
            sel_h1  <= 32'(sel);
            sel_h2  <= sel_h1;
            mode_h1 <= 32'(mode);
            mode_h2 <= mode_h1;
            for (int k = 0; k < 2; k++) begin
                if (upd) begin
                    m_auto[k] <= (period_step(4 - k, m_auto[k], m_cnt[k], m_ch[k], eff_sel, eff_mode, 32'(dwell)) >> 16) & 1;
                    m_cnt[k]  <= (period_step(4 - k, m_auto[k], m_cnt[k], m_ch[k], eff_sel, eff_mode, 32'(dwell)) >> 8) & 8'hff;
                    m_ch[k]   <= period_step(4 - k, m_auto[k], m_cnt[k], m_ch[k], eff_sel, eff_mode, 32'(dwell)) & 8'hff;
                    m_y[k]    <= (d_in >> ((period_step(4 - k, m_auto[k], m_cnt[k], m_ch[k], eff_sel, eff_mode, 32'(dwell)) & 8'hff) * 7)) & 7'h7f;
                    m_sw[k]   <= ((period_step(4 - k, m_auto[k], m_cnt[k], m_ch[k], eff_sel, eff_mode, 32'(dwell)) & 8'hff) != m_ch[k]) ? 1 : 0;
                end else begin
                    m_sw[k] <= 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds inputs for 'gap' cycles, then one upd edge; returns at the following negedge.
    task automatic pulse(input int gap);
        repeat (gap) @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    task automatic set_word(input int k, input logic [6:0] w);
        d_in[k*7 +: 7] = w;
    endtask

    int exp_ch [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int prev_ch;

    initial begin
        // Reset state
        set_word(0, 7'h15);
        set_word(1, 7'h22);
        set_word(2, 7'h40);
        set_word(3, 7'h6b);
        repeat (3) @(negedge clk);
        chk("rst_y", 32'(y4), 0);
        chk("rst_ch", 32'(ch4), 0);
        chk("rst_sw", 32'(sw4), 0);
        rst_n = 1'b1;
        pulse(2);
        chk("first_upd_y", 32'(y4), 32'h15);
        chk("first_upd_sw", 32'(sw4), 0);

        // Manual hold then switch
        sel = 2'd2;
        repeat (10) @(negedge clk);
        chk("hold_y", 32'(y4), 32'h15);
        chk("hold_ch", 32'(ch4), 0);
        pulse(0);
        chk("switch_y", 32'(y4), 32'h40);
        chk("switch_ch", 32'(ch4), 2);
        chk("switch_sw", 32'(sw4), 1);
        @(negedge clk);
        chk("switch_sw_drop", 32'(sw4), 0);
        chk("switch_y_hold", 32'(y4), 32'h40);

        // Clamp on the 3-channel instance
        sel = 2'd3;
        pulse(2);
        chk("clamp_ch3", 32'(ch3), 2);
        chk("clamp_y3", 32'(y3), 32'h40);
        chk("sel3_ch4", 32'(ch4), 3);
        chk("sel3_y4", 32'(y4), 32'h6b);

        // Same channel, new word: refresh without sw
        set_word(3, 7'h0c);
        pulse(2);
        chk("refresh_y", 32'(y4), 32'h0c);
        chk("refresh_sw", 32'(sw4), 0);

        // Auto scan, dwell=2, upd every 8 clocks
        sel = 2'd0;
        pulse(2);
        chk("pre_auto_ch", 32'(ch4), 0);
        mode  = 1'b1;
        dwell = 8'd2;
        prev_ch = 0;
        for (int i = 0; i < 13; i++) begin
            pulse(7);
            chk($sformatf("scan_ch_%0d", i), 32'(ch4), 32'(exp_ch[i]));
            chk($sformatf("scan_sw_%0d", i), 32'(sw4), (exp_ch[i] != prev_ch) ? 1 : 0);
            prev_ch = exp_ch[i];
        end

        // Dwell shrink forces advance, then exit to manual
        pulse(2);
        pulse(2);
        chk("pre_shrink_ch", 32'(ch4), 0);
        dwell = 8'd1;
        pulse(2);
        chk("shrink_ch", 32'(ch4), 1);
        chk("shrink_sw", 32'(sw4), 1);
        mode = 1'b0;
        sel  = 2'd1;
        pulse(2);
        chk("exit_ch", 32'(ch4), 1);
        chk("exit_sw", 32'(sw4), 0);
        mode = 1'b1;
        pulse(2);
        pulse(2);
        chk("cnt_cleared_ch", 32'(ch4), 1);
        pulse(2);
        chk("cnt_cleared_adv", 32'(ch4), 2);
        dwell = 8'd0;
        pulse(2);
        chk("dwell0_ch", 32'(ch4), 3);
        chk("dwell0_y", 32'(y4), 32'h0c);

        // Async reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y4), 0);
        chk("async_rst_ch", 32'(ch4), 0);
        chk("async_rst_sw", 32'(sw4), 0);
        @(negedge clk);
        mode  = 1'b0;
        sel   = 2'd0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef MUX_CTRL_SEQ_SYNC_EN
        sel = 2'd2;
        @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        chk("sync_late_sel", 32'(ch4), 0);
        sel = 2'd1;
        pulse(2);
        chk("sync_early_sel", 32'(ch4), 1);
`endif

        // Randomized phase against the model
        for (int i = 0; i < 800; i++) begin
            chk("rnd_y4", 32'(y4), m_y[0]);
            chk("rnd_ch4", 32'(ch4), m_ch[0]);
            chk("rnd_sw4", 32'(sw4), m_sw[0]);
            chk("rnd_y3", 32'(y3), m_y[1]);
            chk("rnd_ch3", 32'(ch3), m_ch[1]);
            chk("rnd_sw3", 32'(sw3), m_sw[1]);
            upd   = ($urandom_range(0, 2) == 0);
            sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
            d_in  = 28'($urandom);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
